// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// Store buffer: holds dispatched stores until the ROB commits them, drains committed
// stores in order to the dcache and forwards resolved store data to younger loads.
module store_buffer #(
  parameter int SB_ENTRIES      = 4,
  parameter int SB_ENTRY_WIDTH  = 2,
  parameter int ROB_ENTRY_WIDTH = 5,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       alloc_valid_i,
  input  logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_idx_i,
  output logic [SB_ENTRY_WIDTH-1:0]  alloc_idx_o,
  output logic                       full_o,
  output logic                       empty_o,
  input  logic                       exe_valid_i,
  input  logic [SB_ENTRY_WIDTH-1:0]  exe_idx_i,
  input  logic [ADDR_WIDTH-1:0]      exe_addr_i,
  input  logic [DATA_WIDTH-1:0]      exe_data_i,
  input  logic                       exe_byte_i,
  input  logic                       commit_valid_i,
  input  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_idx_i,
  input  logic                       flush_i,
  output logic                       mem_req_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_data_o,
  output logic                       mem_byte_o,
  input  logic                       mem_gnt_i,
  input  logic [ADDR_WIDTH-1:0]      ld_addr_i,
  output logic                       ld_fwd_hit_o,
  output logic [DATA_WIDTH-1:0]      ld_fwd_data_o,
  output logic                       ld_stall_o
);

  typedef logic [SB_ENTRY_WIDTH-1:0] ptr_t;
  typedef logic [SB_ENTRY_WIDTH:0]   cnt_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t head, cmt, tail;
  cnt_t count;

  logic [ROB_ENTRY_WIDTH-1:0] rob_idx [SB_ENTRIES];
  logic [ADDR_WIDTH-1:0]      addr    [SB_ENTRIES];
  logic [DATA_WIDTH-1:0]      data    [SB_ENTRIES];
  logic [SB_ENTRIES-1:0]      byte_st, addr_valid, committed;

  logic alloc_fire, drain_fire;
  ptr_t cmt_next;
  cnt_t committed_next;

  logic                  fwd_match, fwd_unresolved, fwd_byte;
  logic [DATA_WIDTH-1:0] fwd_data;
  ptr_t                  fwd_idx;
  logic                  unused_ld_lsbs;

  assign full_o      = (count == cnt_t'(SB_ENTRIES));
  assign empty_o     = (count == '0);
  assign alloc_idx_o = tail;

  assign mem_req_o  = committed[head] && !empty_o;
  assign mem_addr_o = addr[head];
  assign mem_data_o = data[head];
  assign mem_byte_o = byte_st[head];

  assign alloc_fire = alloc_valid_i && !full_o && !flush_i;
  assign drain_fire = mem_req_o && mem_gnt_i;
  assign cmt_next   = commit_valid_i ? cmt + PTR_ONE : cmt;

  assign unused_ld_lsbs = ^ld_addr_i[1:0];

  // Number of committed entries once this cycle's commit lands; becomes the count on a flush.
  always_comb begin
    committed_next = cnt_t'(commit_valid_i);
    for (int i = 0; i < SB_ENTRIES; i++)
      committed_next = committed_next + cnt_t'(committed[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head       <= '0;
      cmt        <= '0;
      tail       <= '0;
      count      <= '0;
      byte_st    <= '0;
      addr_valid <= '0;
      committed  <= '0;
    end else begin
      if (exe_valid_i) begin
        byte_st[exe_idx_i]    <= exe_byte_i;
        addr_valid[exe_idx_i] <= 1'b1;
      end
      if (commit_valid_i)
        committed[cmt] <= 1'b1;
      if (drain_fire) begin
        committed[head]  <= 1'b0;
        addr_valid[head] <= 1'b0;
        head             <= head + PTR_ONE;
      end
      if (flush_i) begin
        for (int i = 0; i < SB_ENTRIES; i++)
          if (!committed[i] && !(commit_valid_i && ptr_t'(i) == cmt))
            addr_valid[i] <= 1'b0;
        tail  <= cmt_next;
        count <= committed_next - cnt_t'(drain_fire);
      end else begin
        if (alloc_fire) begin
          addr_valid[tail] <= 1'b0;
          committed[tail]  <= 1'b0;
          tail             <= tail + PTR_ONE;
        end
        count <= count + cnt_t'(alloc_fire) - cnt_t'(drain_fire);
      end
      cmt <= cmt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (exe_valid_i) begin
      addr[exe_idx_i] <= exe_addr_i;
      data[exe_idx_i] <= exe_data_i;
    end
    if (alloc_fire)
      rob_idx[tail] <= alloc_rob_idx_i;
  end

  // Walk oldest to youngest so the last word match seen is the youngest one.
  always_comb begin
    fwd_match      = 1'b0;
    fwd_unresolved = 1'b0;
    fwd_byte       = 1'b0;
    fwd_data       = '0;
    fwd_idx        = head;
    for (int k = 0; k < SB_ENTRIES; k++) begin
      fwd_idx = head + ptr_t'(k);
      if (cnt_t'(k) < count) begin
        if (!addr_valid[fwd_idx]) begin
          fwd_unresolved = 1'b1;
        end else if (addr[fwd_idx][ADDR_WIDTH-1:2] == ld_addr_i[ADDR_WIDTH-1:2]) begin
          fwd_match = 1'b1;
          fwd_data  = data[fwd_idx];
          if (byte_st[fwd_idx])
            fwd_byte = 1'b1;
        end
      end
    end
    ld_stall_o    = fwd_unresolved || fwd_byte;
    ld_fwd_hit_o  = fwd_match && !ld_stall_o;
    ld_fwd_data_o = ld_fwd_hit_o ? fwd_data : '0;
  end

  commit_matches_oldest: assert property (@(posedge clk_i) disable iff (!rst_i)
    commit_valid_i |-> (commit_rob_idx_i == rob_idx[cmt] && addr_valid[cmt]));

endmodule
